mac_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the FIR datapath ALU.
- Signed multiply, multiply-add and internal running accumulation behind a valid/ready handshake with backpressure.
- Adds a wide guard-bit accumulator, sticky overflow and clear mode. The FIR controller uses it as its tap engine.

---
 rtl/mac_alu_pipe.sv | 145 ++++++++++++++
 tb/tb_mac_alu_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_alu_pipe.sv
// rtl/mac_alu_pipe.sv - two-stage signed MAC/MUL/ACC/CLR datapath with valid/ready and sticky overflow
// Optional saturation on MAC/ACC overflow is enabled by defining MAC_ALU_SATURATE_EN.
`timescale 1ns/1ps

module mac_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam logic [1:0] OP_MAC = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

`ifdef MAC_ALU_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // run_q keeps in_ready low while reset is held and for the edge that releases it
    logic                      run_q, run_d;
    logic                      s1_valid_q, s1_valid_d;
    logic [1:0]                s1_op_q, s1_op_d;
    logic [ACC_W-1:0]          s1_p_q, s1_p_d;
    logic [ACC_W-1:0]          s1_addend_q, s1_addend_d;
    logic                      out_valid_q, out_valid_d;
    logic [ACC_W-1:0]          result_q, result_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      ovf_q, ovf_d;

    logic                      en;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]          prod_ext;
    logic [ACC_W-1:0]          add_x;
    logic [ACC_W-1:0]          sum;
    logic [ACC_W-1:0]          sum_res;
    logic [ACC_W-1:0]          s2_val;
    logic                      ovf_det;

    always_comb begin
        en       = run_q && (!out_valid_q || out_ready);
        prod     = $signed(a) * $signed(b);
        prod_ext = ACC_W'(prod);

        add_x   = (s1_op_q == OP_ACC) ? acc_q : s1_addend_q;
        sum     = add_x + s1_p_q;
        ovf_det = ((s1_op_q == OP_MAC) || (s1_op_q == OP_ACC)) &&
                  (add_x[ACC_W-1] == s1_p_q[ACC_W-1]) &&
                  (sum[ACC_W-1] != add_x[ACC_W-1]);
`ifdef MAC_ALU_SATURATE_EN
        sum_res = ovf_det ? (add_x[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
        sum_res = sum;
`endif

        case (s1_op_q)
            OP_MAC:  s2_val = sum_res;
            OP_MUL:  s2_val = s1_p_q;
            OP_ACC:  s2_val = sum_res;
            default: s2_val = '0;
        endcase
    end

    always_comb begin
        run_d       = 1'b1;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_p_d      = s1_p_q;
        s1_addend_d = s1_addend_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;

        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d     = op_sel;
                s1_p_d      = prod_ext;
                s1_addend_d = acc_in;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = s2_val;
                if (s1_op_q == OP_ACC) begin
                    acc_d = sum_res;
                end else if (s1_op_q == OP_CLR) begin
                    acc_d = '0;
                end
            end
        end

        // a fresh overflow in the same cycle as a clear request keeps the flag set
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (en && s1_valid_q && ovf_det) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_p_q      <= '0;
            s1_addend_q <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            run_q       <= run_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_p_q      <= s1_p_d;
            s1_addend_q <= s1_addend_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_alu_pipe.sv
// tb/tb_mac_alu_pipe.sv - directed table-driven bench for mac_alu_pipe
`timescale 1ns/1ps

module tb_mac_alu_pipe;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    localparam logic [1:0] OP_MAC = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam longint POS_MAX = 64'sd549755813887;
    localparam longint NEG_MIN = -64'sd549755813888;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [1:0]        op_sel    = 2'b00;
    logic [DATA_W-1:0] a         = '0;
    logic [DATA_W-1:0] b         = '0;
    logic [ACC_W-1:0]  acc_in    = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  result;
    logic              ovf;
    logic              ovf_clr   = 1'b0;

    int     checks   = 0;
    int     failures = 0;
    int     tx_cnt   = 0;
    int     rx_cnt   = 0;
    longint exp_q[$];
    longint cur_exp  = 0;
    longint ovf_exp;

    typedef struct {
        logic [1:0] op;
        int         av;
        int         bv;
        longint     acc;
        longint     exp;
    } vec_t;

    vec_t vecs[14];

    mac_alu_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_sel   (op_sel),
        .a        (a),
        .b        (b),
        .acc_in   (acc_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every accepted beat queues its expected result, every output handshake pops one
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0d expected none", $signed(result));
                end else begin
                    chk("result", $signed(result), exp_q.pop_front());
                    rx_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                tx_cnt++;
            end
        end
    end

    task automatic set_beat(input logic [1:0] op, input int av, input int bv,
                            input longint acc, input longint ex);
        op_sel   = op;
        a        = DATA_W'(av);
        b        = DATA_W'(bv);
        acc_in   = ACC_W'(acc);
        cur_exp  = ex;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int av, input int bv,
                        input longint acc, input longint ex);
        set_beat(op, av, bv, acc, ex);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $finish;
    end

    initial begin
        vecs[0]  = '{OP_MAC, 100, 200, 5, 20005};
        vecs[1]  = '{OP_MUL, -32768, -32768, 0, 1073741824};
        vecs[2]  = '{OP_CLR, 0, 0, 0, 0};
        vecs[3]  = '{OP_ACC, 2, 3, 0, 6};
        vecs[4]  = '{OP_ACC, 4, 5, 0, 26};
        vecs[5]  = '{OP_ACC, -1, 6, 0, 20};
        vecs[6]  = '{OP_CLR, 7, 7, 99, 0};
        vecs[7]  = '{OP_ACC, 1, 1, 0, 1};
        vecs[8]  = '{OP_MUL, 32767, -32768, 0, -1073709056};
        vecs[9]  = '{OP_MAC, -5, 7, -100, -135};
        vecs[10] = '{OP_MUL, 0, -1, 0, 0};
        vecs[11] = '{OP_MUL, -1, -1, 0, 1};
        vecs[12] = '{OP_ACC, -3, 3, 0, -8};
        vecs[13] = '{OP_MAC, 32767, 32767, 0, 1073676289};

`ifdef MAC_ALU_SATURATE_EN
        ovf_exp = POS_MAX;
`else
        ovf_exp = NEG_MIN;
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", $signed(result), 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready_before_clock", in_ready, 0);
        @(posedge clk);
        #1;
        chk("release_in_ready", in_ready, 1);

        // exact two-cycle latency of a single MUL
        set_beat(OP_MUL, 3, -4, 0, -12);
        @(negedge clk);
        chk("lat_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1_out_valid", out_valid, 0);
        chk("lat_c1_result", $signed(result), 0);
        @(negedge clk);
        chk("lat_c2_out_valid", out_valid, 1);
        chk("lat_c2_result", $signed(result), -12);
        @(posedge clk);
        #1;

        // back-to-back table stream
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].acc, vecs[i].exp);
        end
        drain();
        chk("table_ovf", ovf, 0);

        // backpressure mid-stream
        send(OP_MUL, 1, 1, 0, 1);
        send(OP_MUL, 2, 2, 0, 4);
        out_ready = 1'b0;
        set_beat(OP_MUL, 3, 3, 0, 9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result_hold", $signed(result), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept();
        send(OP_MUL, 4, 4, 0, 16);
        drain();
        chk("stall_tx_rx", rx_cnt, tx_cnt);

        // overflow on MAC, sticky across CLR, then cleared
        send(OP_MAC, 1, 1, POS_MAX, ovf_exp);
        drain();
        chk("ovf_set", ovf, 1);
        send(OP_CLR, 0, 0, 0, 0);
        drain();
        chk("ovf_survives_clr_op", ovf, 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // overflow coinciding with ovf_clr keeps the flag set
        ovf_clr = 1'b1;
        send(OP_MAC, 1, 1, POS_MAX, ovf_exp);
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
            chk("ovf_set_wins_valid", out_valid, 1);
            chk("ovf_set_wins", ovf, 1);
        end
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_clear_after_set_wins", ovf, 0);
        drain();

        // reset with beats in flight
        send(OP_MUL, 5, 5, 0, 25);
        send(OP_MUL, 6, 6, 0, 36);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", $signed(result), 0);
        chk("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        tx_cnt = 0;
        rx_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(OP_ACC, 1, 2, 0, 2);
        drain();
        chk("post_rst_tx_rx", rx_cnt, tx_cnt);
        chk("post_rst_rx_count", rx_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
